ysyx_22040386_alu_seq: RTL and testbench
========================================

# ysyx_22040386_alu_seq

Multi-cycle execute sequencer that owns the single shared ALU in the NPC core. It accepts one decoded instruction at a time over a valid/ready handshake. It drives the ALU operands and `ALUctr` for one or two passes: compare then target for branches, link then target for jumps. It returns the rd write data, next PC and branch-taken flag to writeback.

## Interface
- `XLEN`, default 64: datapath width.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decoded instruction valid.
- `in_ready` out 1: sequencer can accept; high only in IDLE.
- `in_class` in 3: instruction class; 0 R-ALU, 1 I-ALU, 2 BRANCH, 3 JAL, 4 JALR, 5–7 reserved.
- `in_funct3` in 3 / `in_funct7` in 7: instruction function fields.
- `in_pc`, `in_rs1`, `in_rs2`, `in_imm` in XLEN: PC, operands, sign-extended immediate.
- `alu_a`, `alu_b` out XLEN: ALU operands.
- `alu_ctr` out 5: ALU control code.
- `alu_result` in XLEN: combinational ALU result for the current `alu_a`/`alu_b`/`alu_ctr`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: writeback accepts the result.
- `out_rd_data`, `out_next_pc` out XLEN: rd write value and next PC.
- `out_taken` out 1: high when the branch is taken or the instruction is a jump.

## Operation
- States:
  - IDLE: `in_ready=1`. On `in_valid` the sequencer latches all `in_*` fields and goes to OP1.
  - OP1: first ALU pass.
  - OP2: second ALU pass.
  - DONE: `out_valid=1`. On `out_ready` it goes to IDLE. There is no same-cycle re-accept.
- ALU drive in IDLE and DONE: `alu_a=alu_b=0`, `alu_ctr=5'b00000`.
- Code mapping:
  - add 00000, sub 10000, sll 00100, slt 11111, sltu 10111, xor 00011, srl 00101, sra 10110, or 00010, and 00001.
  - sub and sra are selected only when `funct7==7'b0100000`.
  - I-type funct3 000 is always add.
- R-ALU, OP1: a=rs1, b=rs2, code from funct3/funct7. `rd_data=alu_result`, `next_pc=pc+4`, `taken=0`. Goes to DONE.
- I-ALU: as R-ALU but b=imm.
- BRANCH, OP1: a=rs1, b=rs2.
  - beq/bne use sub; taken on result==0 / result!=0.
  - blt/bge use slt; taken on result[0]==1 / result[0]==0.
  - bltu/bgeu use sltu with the same result[0] rule.
  - funct3 010/011 use add and are never taken.
  - Taken: go to OP2, a=pc, b=imm, add, `next_pc=alu_result`.
  - Not taken: `next_pc=pc+4` and go straight to DONE.
  - `rd_data=0` in both cases.
- JAL:
  - OP1: a=pc, b=4, add → `rd_data`.
  - OP2: a=pc, b=imm, add → `next_pc`.
  - `taken=1`.
- JALR: as JAL, but OP2 uses a=rs1 and `next_pc=alu_result & ~1`.
- Reserved class: skips the ALU (drive stays zero). OP1 → DONE with `rd_data=0`, `next_pc=pc+4`, `taken=0`.
- `pc+4` outside the ALU comes from a private incrementer. All other arithmetic goes through the ALU at XLEN width, wrapping modulo 2^XLEN.

## Timing
- Reset values: state=IDLE, `in_ready=1` (combinational from state), `out_valid=0`, `out_rd_data=0`, `out_next_pc=0`, `out_taken=0`, `alu_a=alu_b=0`, `alu_ctr=0`.
- Accept at edge 0. The first ALU pass is in cycle 1.
- `out_valid` rises:
  - cycle 2 for ALU, not-taken branch and reserved class;
  - cycle 3 for taken branch, JAL and JALR.
- `alu_*` are combinational from state and the latched fields. Results are registered on the edge leaving OP1/OP2.
- `out_*` hold stable while `out_valid && !out_ready`.
- `rst` in any state aborts the instruction immediately. No `out_valid` is produced for it.

## Structure
- Package `ysyx_22040386_alu_pkg` holds:
  - class constants;
  - the 5-bit ALU code constants listed above;
  - the state enum (IDLE/OP1/OP2/DONE);
  - ALUop encodings (00 add, 01 I, 10 R, 11 B).
- Sub-module: instantiate the existing `ysyx_22040386_ALUcontrol` to map class and funct fields to `ALUctr` for the OP1 pass. Force add during OP2 and for the JAL/JALR link pass.

## Test plan
- R sub, rs1=10, rs2=3, funct7=0x20: `alu_ctr=10000` in cycle 1; cycle 2 `out_valid`, `rd_data=7`, `next_pc=pc+4`.
- beq, rs1=rs2=5, pc=0x80000000, imm=0x10: OP1 ctr 10000, OP2 ctr 00000; cycle 3 `taken=1`, `next_pc=0x80000010`.
- blt, rs1=5, rs2=-1: ctr 11111; cycle 2 `taken=0`, `next_pc=pc+4`, `rd_data=0`.
- JALR, pc=0x80000000, rs1=0x80000103, imm=4: `rd_data=0x80000004`, `next_pc=0x80000106`, `taken=1`.
- Hold `out_ready` low 3 cycles in DONE: outputs stable, `in_ready=0`, ALU drive zero; accepted the cycle `out_ready` rises, IDLE next.
- Assert `rst` during OP1 of a JAL: `out_valid` stays 0 and outputs read zero; `in_ready=1` once reset is released.

Source files
------------

// File: rtl/ysyx_22040386_alu_seq_pkg.sv
// Shared constants for the execute sequencer: instruction classes, ALU
// control codes, ALUop selectors and the sequencer state encoding.
package ysyx_22040386_alu_pkg;

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_I    = 3'd1;
  localparam logic [2:0] CLS_B    = 3'd2;
  localparam logic [2:0] CLS_JAL  = 3'd3;
  localparam logic [2:0] CLS_JALR = 3'd4;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b10000;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b11111;
  localparam logic [4:0] ALU_SLTU = 5'b10111;
  localparam logic [4:0] ALU_XOR  = 5'b00011;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b10110;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00001;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_I   = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_B   = 2'b11;

  // funct7 pattern that selects sub / sra
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [1:0] {ST_IDLE, ST_OP1, ST_OP2, ST_DONE} state_t;

endpackage

// File: rtl/ysyx_22040386_alu_seq_if.sv
// Handshake and ALU-side bundle of the execute sequencer. slave = sequencer,
// master = the surrounding pipeline (decode, ALU, writeback).
interface ysyx_22040386_alu_seq_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_class;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_ctr;
  logic [XLEN-1:0] alu_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd_data;
  logic [XLEN-1:0] out_next_pc;
  logic            out_taken;

  modport slave (
    input  in_valid, in_class, in_funct3, in_funct7, in_pc, in_rs1, in_rs2, in_imm,
    input  alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_ctr, out_valid, out_rd_data, out_next_pc, out_taken
  );

  modport master (
    output in_valid, in_class, in_funct3, in_funct7, in_pc, in_rs1, in_rs2, in_imm,
    output alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_ctr, out_valid, out_rd_data, out_next_pc, out_taken
  );
endinterface

// File: rtl/ysyx_22040386_alu_seq_alucontrol.sv
// Maps ALUop plus funct3/funct7 to the 5-bit ALU control code.
module ysyx_22040386_ALUcontrol
  import ysyx_22040386_alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] alu_ctr
);
  logic alt;
  assign alt = (funct7 == F7_ALT);

  // R and I share the table; only I-type funct3 000 ignores funct7
  always_comb begin
    alu_ctr = ALU_ADD;
    case (alu_op)
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000: alu_ctr = (alu_op == ALUOP_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctr = ALU_SLL;
          3'b010: alu_ctr = ALU_SLT;
          3'b011: alu_ctr = ALU_SLTU;
          3'b100: alu_ctr = ALU_XOR;
          3'b101: alu_ctr = alt ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctr = ALU_OR;
          default: alu_ctr = ALU_AND;
        endcase
      end
      ALUOP_B: begin
        case (funct3)
          3'b000, 3'b001: alu_ctr = ALU_SUB;
          3'b100, 3'b101: alu_ctr = ALU_SLT;
          3'b110, 3'b111: alu_ctr = ALU_SLTU;
          default:        alu_ctr = ALU_ADD;
        endcase
      end
      default: alu_ctr = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/ysyx_22040386_alu_seq.sv
// Multi-cycle execute sequencer owning the shared ALU: one or two ALU passes
// per instruction, result handed to writeback over valid/ready.
module ysyx_22040386_alu_seq
  import ysyx_22040386_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040386_alu_seq_if.slave bus
);
  state_t state, state_nxt;

  logic [2:0]      r_cls, r_f3;
  logic [6:0]      r_f7;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
  logic [XLEN-1:0] rd_q, npc_q;
  logic            taken_q;

  logic [1:0]      alu_op;
  logic [4:0]      ctl_ctr;
  logic [XLEN-1:0] a_d, b_d, pc4;
  logic [4:0]      ctr_d;
  logic            br_take, need_op2;

  assign pc4 = r_pc + XLEN'(4);

  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.out_rd_data = rd_q;
  assign bus.out_next_pc = npc_q;
  assign bus.out_taken   = taken_q;
  assign bus.alu_a       = a_d;
  assign bus.alu_b       = b_d;
  assign bus.alu_ctr     = ctr_d;

  // ALUop only decodes funct fields on the first pass; everything else is add
  always_comb begin
    alu_op = ALUOP_ADD;
    if (state == ST_OP1) begin
      case (r_cls)
        CLS_R:   alu_op = ALUOP_R;
        CLS_I:   alu_op = ALUOP_I;
        CLS_B:   alu_op = ALUOP_B;
        default: alu_op = ALUOP_ADD;
      endcase
    end
  end

  ysyx_22040386_ALUcontrol u_ctl (
    .alu_op  (alu_op),
    .funct3  (r_f3),
    .funct7  (r_f7),
    .alu_ctr (ctl_ctr)
  );

  // ALU operand/control drive; zero outside the two passes and for reserved class
  always_comb begin
    a_d   = '0;
    b_d   = '0;
    ctr_d = ALU_ADD;
    if (state == ST_OP1) begin
      case (r_cls)
        CLS_R:           begin a_d = r_rs1; b_d = r_rs2;       ctr_d = ctl_ctr; end
        CLS_I:           begin a_d = r_rs1; b_d = r_imm;       ctr_d = ctl_ctr; end
        CLS_B:           begin a_d = r_rs1; b_d = r_rs2;       ctr_d = ctl_ctr; end
        CLS_JAL, CLS_JALR: begin a_d = r_pc; b_d = XLEN'(4);   ctr_d = ALU_ADD; end
        default: ;
      endcase
    end else if (state == ST_OP2) begin
      a_d   = (r_cls == CLS_JALR) ? r_rs1 : r_pc;
      b_d   = r_imm;
      ctr_d = ALU_ADD;
    end
  end

  // branch outcome from the first-pass compare result
  always_comb begin
    br_take = 1'b0;
    case (r_f3)
      3'b000:         br_take = (bus.alu_result == '0);
      3'b001:         br_take = (bus.alu_result != '0);
      3'b100, 3'b110: br_take =  bus.alu_result[0];
      3'b101, 3'b111: br_take = ~bus.alu_result[0];
      default:        br_take = 1'b0;
    endcase
  end

  assign need_op2 = (r_cls == CLS_JAL) || (r_cls == CLS_JALR) || (r_cls == CLS_B && br_take);

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_OP1;
      ST_OP1:  state_nxt = need_op2 ? ST_OP2 : ST_DONE;
      ST_OP2:  state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // field capture on accept, result capture on the edge leaving each pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls <= '0; r_f3 <= '0; r_f7 <= '0;
      r_pc  <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
      rd_q  <= '0; npc_q <= '0; taken_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          r_cls <= bus.in_class;  r_f3  <= bus.in_funct3; r_f7 <= bus.in_funct7;
          r_pc  <= bus.in_pc;     r_rs1 <= bus.in_rs1;
          r_rs2 <= bus.in_rs2;    r_imm <= bus.in_imm;
        end
        ST_OP1: begin
          case (r_cls)
            CLS_R, CLS_I: begin rd_q <= bus.alu_result; npc_q <= pc4; taken_q <= 1'b0; end
            CLS_B: begin
              rd_q    <= '0;
              taken_q <= br_take;
              if (!br_take) npc_q <= pc4;
            end
            CLS_JAL, CLS_JALR: begin rd_q <= bus.alu_result; taken_q <= 1'b1; end
            default: begin rd_q <= '0; npc_q <= pc4; taken_q <= 1'b0; end
          endcase
        end
        ST_OP2: npc_q <= (r_cls == CLS_JALR) ? (bus.alu_result & ~XLEN'(1)) : bus.alu_result;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040386_alu_seq.sv
// Randomized bench for the execute sequencer with a behavioural ALU and a
// spec-level reference model of each instruction's results and timing.
module tb_ysyx_22040386_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  ysyx_22040386_alu_seq_if #(.XLEN(64)) bus();

  ysyx_22040386_alu_seq #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // shared ALU seen by the sequencer
  always_comb begin
    case (bus.alu_ctr)
      5'b00000: bus.alu_result = bus.alu_a + bus.alu_b;
      5'b10000: bus.alu_result = bus.alu_a - bus.alu_b;
      5'b00100: bus.alu_result = bus.alu_a << bus.alu_b[5:0];
      5'b11111: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 64'd1 : 64'd0;
      5'b10111: bus.alu_result = (bus.alu_a < bus.alu_b) ? 64'd1 : 64'd0;
      5'b00011: bus.alu_result = bus.alu_a ^ bus.alu_b;
      5'b00101: bus.alu_result = bus.alu_a >> bus.alu_b[5:0];
      5'b10110: bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[5:0];
      5'b00010: bus.alu_result = bus.alu_a | bus.alu_b;
      5'b00001: bus.alu_result = bus.alu_a & bus.alu_b;
      default:  bus.alu_result = 64'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rd, npc;
    logic        taken;
    int          lat;
    logic [4:0]  c1;
    logic [63:0] a1, b1, a2, b2;
  } exp_t;

  function automatic exp_t ref_model(input logic [2:0] cls, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [63:0] pc,
                                     input logic [63:0] rs1, input logic [63:0] rs2,
                                     input logic [63:0] imm);
    exp_t e;
    logic [63:0] b;
    logic alt;
    alt = (f7 == 7'h20);
    e.rd = 0; e.npc = pc + 64'd4; e.taken = 1'b0; e.lat = 2;
    e.c1 = 5'b00000; e.a1 = 0; e.b1 = 0; e.a2 = 0; e.b2 = 0;
    case (cls)
      3'd0, 3'd1: begin
        b = (cls == 3'd0) ? rs2 : imm;
        e.a1 = rs1; e.b1 = b;
        case (f3)
          3'b000: if (cls == 3'd0 && alt) begin e.rd = rs1 - b; e.c1 = 5'b10000; end
                  else begin e.rd = rs1 + b; e.c1 = 5'b00000; end
          3'b001: begin e.rd = rs1 << b[5:0]; e.c1 = 5'b00100; end
          3'b010: begin e.rd = ($signed(rs1) < $signed(b)) ? 64'd1 : 64'd0; e.c1 = 5'b11111; end
          3'b011: begin e.rd = (rs1 < b) ? 64'd1 : 64'd0; e.c1 = 5'b10111; end
          3'b100: begin e.rd = rs1 ^ b; e.c1 = 5'b00011; end
          3'b101: if (alt) begin e.rd = $signed(rs1) >>> b[5:0]; e.c1 = 5'b10110; end
                  else begin e.rd = rs1 >> b[5:0]; e.c1 = 5'b00101; end
          3'b110: begin e.rd = rs1 | b; e.c1 = 5'b00010; end
          default: begin e.rd = rs1 & b; e.c1 = 5'b00001; end
        endcase
      end
      3'd2: begin
        e.a1 = rs1; e.b1 = rs2;
        case (f3)
          3'b000: begin e.taken = (rs1 == rs2); e.c1 = 5'b10000; end
          3'b001: begin e.taken = (rs1 != rs2); e.c1 = 5'b10000; end
          3'b100: begin e.taken = ($signed(rs1) <  $signed(rs2)); e.c1 = 5'b11111; end
          3'b101: begin e.taken = ($signed(rs1) >= $signed(rs2)); e.c1 = 5'b11111; end
          3'b110: begin e.taken = (rs1 <  rs2); e.c1 = 5'b10111; end
          3'b111: begin e.taken = (rs1 >= rs2); e.c1 = 5'b10111; end
          default: begin e.taken = 1'b0; e.c1 = 5'b00000; end
        endcase
        if (e.taken) begin e.npc = pc + imm; e.lat = 3; e.a2 = pc; e.b2 = imm; end
      end
      3'd3, 3'd4: begin
        e.rd = pc + 64'd4; e.taken = 1'b1; e.lat = 3;
        e.a1 = pc; e.b1 = 64'd4; e.b2 = imm;
        e.a2 = (cls == 3'd3) ? pc : rs1;
        e.npc = (cls == 3'd3) ? pc + imm : ((rs1 + imm) & ~64'd1);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_inputs();
    bus.in_class = 3'($urandom); bus.in_funct3 = 3'($urandom); bus.in_funct7 = 7'($urandom);
    bus.in_pc = rnd64(); bus.in_rs1 = rnd64(); bus.in_rs2 = rnd64(); bus.in_imm = rnd64();
  endtask

  task automatic drive(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm);
    bus.in_valid = 1'b1; bus.in_class = cls; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
  endtask

  task automatic run_txn(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] pc, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] imm, input int hold);
    exp_t e;
    int   cyc;
    e = ref_model(cls, f3, f7, pc, rs1, rs2, imm);
    chk("idle_in_ready", bus.in_ready, 1);
    drive(cls, f3, f7, pc, rs1, rs2, imm);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    cyc = 1;
    chk("op1_in_ready", bus.in_ready, 0);
    chk("op1_ctr", bus.alu_ctr, e.c1);
    chk("op1_a", bus.alu_a, e.a1);
    chk("op1_b", bus.alu_b, e.b1);
    if (e.lat == 3) begin
      @(negedge clk);
      cyc = 2;
      chk("op2_valid", bus.out_valid, 0);
      chk("op2_ctr", bus.alu_ctr, 0);
      chk("op2_a", bus.alu_a, e.a2);
      chk("op2_b", bus.alu_b, e.b2);
    end
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 10);
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("rd_data", bus.out_rd_data, e.rd);
    chk("next_pc", bus.out_next_pc, e.npc);
    chk("taken", bus.out_taken, e.taken);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_rd", bus.out_rd_data, e.rd);
      chk("hold_npc", bus.out_next_pc, e.npc);
      chk("hold_taken", bus.out_taken, e.taken);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_alu_a", bus.alu_a, 0);
      chk("hold_alu_ctr", bus.alu_ctr, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ret_in_ready", bus.in_ready, 1);
    chk("ret_valid", bus.out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_rd"}, bus.out_rd_data, 0);
    chk({tag, "_npc"}, bus.out_next_pc, 0);
    chk({tag, "_taken"}, bus.out_taken, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_ctr"}, bus.alu_ctr, 0);
  endtask

  initial begin
    logic [63:0] r1, simm;
    logic [2:0]  cls;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    scramble_inputs();
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_txn(3'd0, 3'b000, 7'h20, 64'h1000, 64'd10, 64'd3, 64'd0, 0);
    run_txn(3'd2, 3'b000, 7'h00, 64'h80000000, 64'd5, 64'd5, 64'h10, 0);
    run_txn(3'd2, 3'b100, 7'h00, 64'h2000, 64'd5, 64'hffff_ffff_ffff_ffff, 64'h40, 0);
    run_txn(3'd4, 3'b000, 7'h00, 64'h80000000, 64'h80000103, 64'd0, 64'd4, 0);
    run_txn(3'd0, 3'b111, 7'h00, 64'h3000, 64'hf0f0, 64'hff00, 64'd0, 3);
    run_txn(3'd5, 3'b000, 7'h00, 64'hffff_ffff_ffff_fffc, 64'd1, 64'd2, 64'd3, 1);
    run_txn(3'd1, 3'b101, 7'h20, 64'h4000, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 0);

    // reset while a JAL is in its first pass
    drive(3'd3, 3'b000, 7'h00, 64'h80000000, 64'd0, 64'd0, 64'h100);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("jal_op1_a", bus.alu_a, 64'h80000000);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_valid", bus.out_valid, 0);
      chk("post_abort_in_ready", bus.in_ready, 1);
    end

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      cls  = 3'($urandom_range(0, 7));
      r1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : rnd64();
      simm = {{52{1'b0}}, 12'($urandom)};
      simm = {{52{simm[11]}}, simm[11:0]};
      run_txn(cls, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rnd64(), r1,
              ($urandom_range(0, 2) == 0) ? r1 : rnd64(), simm, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
